// File: rtl/dist_mem_responder.sv
// dist_mem_responder: memory-side responder for the CPU distribution port.
// Moves one 256-bit distribution (8 x 32-bit words) against a word-wide RAM,
// one word per cycle, and holds clk_stall high until the transfer completes.
// Optional build macro: DIST_BOUNDS_CHECK_EN. When it is defined, a transfer
// whose last word would fall past the top of the RAM performs no RAM access
// and sets err. When it is undefined, word addresses wrap modulo RAM depth.
module dist_mem_responder #(
    parameter int WORD_ADDR_W = 10,
    parameter int RAM_RD_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            addr,
    input  logic                   DMemRead,
    input  logic                   DMemWrite,
    input  logic [255:0]           dist_in,
    output logic [255:0]           dist_out,
    output logic                   clk_stall,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [31:0]            mem_wdata,
    output logic                   mem_we,
    input  logic [31:0]            mem_rdata,
    output logic                   err
);

    // The capture schedule below assumes read data one cycle after the address.
    generate
        if (RAM_RD_LAT != 1) begin : g_bad_rd_lat
            $error("dist_mem_responder: only RAM_RD_LAT == 1 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             idx;
    logic [WORD_ADDR_W-1:0] base;
    logic [255:0]           wbuf;
    logic                   oob;

    logic                   req;
    logic [WORD_ADDR_W-1:0] req_base;
    logic                   req_oob;
    logic [31:0]            rd_word;

    // Only addr[WORD_ADDR_W+4:5] selects the base; the rest is don't-care.
    logic unused_addr;
    assign unused_addr = ^addr;

    assign req      = DMemRead | DMemWrite;
    assign req_base = addr[WORD_ADDR_W+4:5];

`ifdef DIST_BOUNDS_CHECK_EN
    // Carry out of base+7 means the last word lies beyond the top of the RAM.
    logic [WORD_ADDR_W:0] req_last;
    assign req_last = {1'b0, req_base} + (WORD_ADDR_W + 1)'(7);
    assign req_oob  = req_last[WORD_ADDR_W];
`else
    assign req_oob  = 1'b0;
`endif

    // An out-of-range read returns zeros instead of whatever the RAM holds.
    assign rd_word = oob ? 32'd0 : mem_rdata;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Transfer context, word index, read capture and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= 3'd0;
            base     <= '0;
            // NOTE: the 256-bit buffers are plain flops, not a RAM, so they take
            // the async reset like everything else and never expose stale data.
            wbuf     <= '0;
            oob      <= 1'b0;
            dist_out <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        base <= req_base;
                        wbuf <= dist_in;
                        oob  <= req_oob;
                        idx  <= 3'd0;
                        if ((DMemRead && DMemWrite) || req_oob) begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Data for word idx-1 arrives while word idx is addressed.
                    if (idx != 3'd0) begin
                        dist_out[{idx - 3'd1, 5'd0} +: 32] <= rd_word;
                    end
                    idx <= idx + 3'd1;
                end
                DRAIN: begin
                    dist_out[255:224] <= rd_word;
                end
                WRITE: begin
                    idx <= idx + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and RAM/stall outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        clk_stall = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        case (state)
            IDLE: begin
                // Raised combinationally so the CPU clock is held before its next edge.
                clk_stall = req;
                if (req) begin
                    state_nxt = DMemWrite ? WRITE : READ;
                end
            end
            READ: begin
                clk_stall = 1'b1;
                mem_addr  = base + WORD_ADDR_W'(idx);
                if (idx == 3'd7) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                clk_stall = 1'b1;
                state_nxt = DONE;
            end
            WRITE: begin
                clk_stall = 1'b1;
                mem_we    = ~oob;
                mem_addr  = base + WORD_ADDR_W'(idx);
                mem_wdata = wbuf[{idx, 5'd0} +: 32];
                if (idx == 3'd7) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // One unstalled cycle lets the CPU advance; requests are ignored.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dist_mem_responder.sv
// tb_dist_mem_responder: self-checking bench for dist_mem_responder.
// Backing RAM is a behavioural 1-cycle-latency array. Expected RAM writes and
// read payloads go into scoreboard queues when a transfer is issued and are
// popped as the DUT produces them.
module tb_dist_mem_responder;

    localparam int AW = 10;

    logic           clk;
    logic           reset_n;
    logic [31:0]    addr;
    logic           DMemRead;
    logic           DMemWrite;
    logic [255:0]   dist_in;
    logic [255:0]   dist_out;
    logic           clk_stall;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_wdata;
    logic           mem_we;
    logic [31:0]    mem_rdata;
    logic           err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    typedef struct {
        bit            rd;
        bit            wr;
        logic [31:0]   a;
        logic [255:0]  data;
        int            stall;
    } vec_t;

    wr_t          exp_wq[$];
    logic [255:0] exp_rq[$];
    logic [255:0] last_rd;

    logic [31:0] ram [0:(1<<AW)-1];

    dist_mem_responder #(
        .WORD_ADDR_W(AW),
        .RAM_RD_LAT (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .DMemRead (DMemRead),
        .DMemWrite(DMemWrite),
        .dist_in  (dist_in),
        .dist_out (dist_out),
        .clk_stall(clk_stall),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural backing RAM, read data valid one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_wq.size() == 0) begin
                check("unexpected_we", {255'd0, mem_we}, 256'd0);
            end else begin
                wr_t w;
                w = exp_wq.pop_front();
                check("wr_addr", {{(256-AW){1'b0}}, mem_addr}, {{(256-AW){1'b0}}, w.a});
                check("wr_data", {224'd0, mem_wdata}, {224'd0, w.d});
            end
        end
    end

    function automatic logic [255:0] mk(input logic [31:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = b + 32'(i);
        return r;
    endfunction

    // Issue one transfer, count stall cycles, and stop in DONE.
    task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [255:0] data, input int exp_stall, input bit hold);
        int            cnt;
        logic [AW-1:0] b;
        bit            oob;
        wr_t           w;
        b   = a[AW+4:5];
        oob = 1'b0;
`ifdef DIST_BOUNDS_CHECK_EN
        oob = (int'(b) + 7) > ((1 << AW) - 1);
`endif
        if (wr && !oob) begin
            for (int i = 0; i < 8; i++) begin
                w.a = b + AW'(i);
                w.d = data[32*i +: 32];
                exp_wq.push_back(w);
            end
        end
        if (rd && !wr) exp_rq.push_back(oob ? 256'd0 : data);
        @(posedge clk);
        @(negedge clk);
        DMemRead  = rd;
        DMemWrite = wr;
        addr      = a;
        dist_in   = data;
        #1;
        cnt = 0;
        while (clk_stall === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("stall_len", 256'(cnt), 256'(exp_stall));
        check("done_we_low", {255'd0, mem_we}, 256'd0);
        if (!hold) begin
            DMemRead  = 1'b0;
            DMemWrite = 1'b0;
        end
        if (rd && !wr) begin
            last_rd = exp_rq.pop_front();
            check("dist_out", dist_out, last_rd);
        end else begin
            check("dist_out_kept", dist_out, last_rd);
        end
        check("wq_drained", 256'(exp_wq.size()), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[6];
        logic [255:0]  pat_b;
        logic [255:0]  pat_c;
        logic [255:0]  pat_d;
        logic [31:0]   snap[8];
        bit            found;
        bit            exp_bounds_err;

        pat_b = mk(32'hB000_0000);
        pat_c = mk(32'hC000_0000);
        pat_d = mk(32'hD000_0000);
        vecs[0] = '{rd: 1'b0, wr: 1'b1, a: 32'h0000_0040, data: mk(32'd0),         stall: 9};
        vecs[1] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_0040, data: mk(32'd0),         stall: 10};
        vecs[2] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_005F, data: mk(32'd0),         stall: 10};
        vecs[3] = '{rd: 1'b0, wr: 1'b1, a: 32'h0000_1000, data: mk(32'hA5A5_0000), stall: 9};
        vecs[4] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_1000, data: mk(32'hA5A5_0000), stall: 10};
        vecs[5] = '{rd: 1'b1, wr: 1'b0, a: 32'h0000_0040, data: mk(32'd0),         stall: 10};

        reset_n   = 1'b1;
        DMemRead  = 1'b0;
        DMemWrite = 1'b0;
        addr      = 32'd0;
        dist_in   = 256'd0;
        last_rd   = 256'd0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_dist_out",  dist_out, 256'd0);
        check("rst_stall",     {255'd0, clk_stall}, 256'd0);
        check("rst_we",        {255'd0, mem_we}, 256'd0);
        check("rst_mem_addr",  {{(256-AW){1'b0}}, mem_addr}, 256'd0);
        check("rst_mem_wdata", {224'd0, mem_wdata}, 256'd0);
        check("rst_err",       {255'd0, err}, 256'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Table-driven transfers: write/read round trips and low-address-bit masking.
        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].data, vecs[i].stall, 1'b0);
            check("err_clear", {255'd0, err}, 256'd0);
        end

        // Request held through DONE restarts a transfer in the following IDLE.
        do_xfer(1'b1, 1'b0, 32'h0000_0040, mk(32'd0), 10, 1'b1);
        check("done_stall_low", {255'd0, clk_stall}, 256'd0);
        @(posedge clk);
        #1;
        check("b2b_restall", {255'd0, clk_stall}, 256'd1);
        DMemRead = 1'b0;
        #1;
        check("idle_release", {255'd0, clk_stall}, 256'd0);

        // Simultaneous read and write: write wins, err sticks.
        do_xfer(1'b1, 1'b1, 32'h0000_0080, pat_b, 9, 1'b0);
        check("both_err", {255'd0, err}, 256'd1);
        do_xfer(1'b1, 1'b0, 32'h0000_0080, pat_b, 10, 1'b0);
        check("err_sticky", {255'd0, err}, 256'd1);

        // Reset while word 3 of a write is on the RAM port.
        for (int i = 0; i < 8; i++) snap[i] = ram[256 + i];
        for (int i = 0; i < 3; i++) begin
            wr_t w;
            w.a = AW'(256 + i);
            w.d = pat_c[32*i +: 32];
            exp_wq.push_back(w);
        end
        @(posedge clk);
        @(negedge clk);
        DMemWrite = 1'b1;
        addr      = 32'h0000_2000;
        dist_in   = pat_c;
        found     = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (mem_we === 1'b1 && mem_addr == AW'(259)) found = 1'b1;
        end
        check("rst_wait", {255'd0, found}, 256'd1);
        reset_n   = 1'b0;
        DMemWrite = 1'b0;
        #1;
        last_rd = 256'd0;
        check("midrst_we",       {255'd0, mem_we}, 256'd0);
        check("midrst_stall",    {255'd0, clk_stall}, 256'd0);
        check("midrst_dist_out", dist_out, 256'd0);
        check("midrst_err",      {255'd0, err}, 256'd0);
        for (int i = 0; i < 3; i++) check("midrst_written", {224'd0, ram[256 + i]}, {224'd0, pat_c[32*i +: 32]});
        for (int i = 3; i < 8; i++) check("midrst_untouched", {224'd0, ram[256 + i]}, {224'd0, snap[i]});
        check("midrst_wq", 256'(exp_wq.size()), 256'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Base at depth-4: wraps by default, suppressed with bounds checking.
`ifdef DIST_BOUNDS_CHECK_EN
        exp_bounds_err = 1'b1;
`else
        exp_bounds_err = 1'b0;
`endif
        do_xfer(1'b0, 1'b1, 32'h0000_7F80, pat_d, 9, 1'b0);
        check("bounds_err", {255'd0, err}, {255'd0, exp_bounds_err});
        do_xfer(1'b1, 1'b0, 32'h0000_7F80, pat_d, 10, 1'b0);
        check("bounds_err_rd", {255'd0, err}, {255'd0, exp_bounds_err});

        repeat (2) @(negedge clk);
        check("final_wq", 256'(exp_wq.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
